// File: rtl/mult_ctrl_pkg.sv
// Shared types and constants for the add/shift multiplier controller.
// The state enum and adder function codes live here so datapath blocks can use them too.
package mult_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    HOLD  = 3'd4
  } state_t;

  localparam logic FN_ADD = 1'b0;
  localparam logic FN_SUB = 1'b1;

endpackage

// File: rtl/multiplier_control.sv
// Sequencer for a shift-add signed multiplier: clear, WIDTH add/shift pairs
// (subtract on the final, sign-weighted bit), then hold the product until Run drops.
module multiplier_control
  import mult_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic Clear_AX,
  output logic Ld_B,
  output logic Ld_A,
  output logic Shift_En,
  output logic Fn,
  output logic Busy,
  output logic Done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          last_bit;

  assign last_bit = (count == LAST);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    Clear_AX   = 1'b0;
    Ld_B       = 1'b0;
    Ld_A       = 1'b0;
    Shift_En   = 1'b0;
    Fn         = FN_ADD;
    Busy       = 1'b0;
    Done       = 1'b0;

    case (state)
      IDLE: begin
        if (ClearA_LoadB) begin
          Ld_B     = 1'b1;
          Clear_AX = 1'b1;
        end else if (Run) begin
          state_next = START;
        end
      end
      START: begin
        Clear_AX   = 1'b1;
        Busy       = 1'b1;
        count_next = '0;
        state_next = ADD;
      end
      ADD: begin
        Busy       = 1'b1;
        Ld_A       = M;
        Fn         = last_bit ? FN_SUB : FN_ADD;
        state_next = SHIFT;
      end
      SHIFT: begin
        Busy     = 1'b1;
        Shift_En = 1'b1;
        // The counter parks at LAST instead of wrapping back to zero.
        if (last_bit) begin
          state_next = HOLD;
        end else begin
          count_next = count + 1'b1;
          state_next = ADD;
        end
      end
      HOLD: begin
        Done = 1'b1;
        if (!Run) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Reset silences every control line immediately, not just at the next edge.
    if (!Reset_n) begin
      Clear_AX = 1'b0;
      Ld_B     = 1'b0;
      Ld_A     = 1'b0;
      Shift_En = 1'b0;
      Fn       = FN_ADD;
      Busy     = 1'b0;
      Done     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multiplier_control.sv
// Scoreboard bench for multiplier_control: the stimulus side queues the expected
// control word for each cycle and a negedge monitor pops and compares it.
module tb_multiplier_control;

  localparam int W = 8;

  typedef struct packed {
    logic clear_ax;
    logic ld_b;
    logic ld_a;
    logic shift_en;
    logic fn;
    logic busy;
    logic done;
  } outs_t;

  typedef struct {
    outs_t e;
    string name;
    int    k;
  } exp_item_t;

  localparam outs_t NONE   = 7'b0000000;
  localparam outs_t CLR_LD = 7'b1100000;
  localparam int    NO_CLR = 100000;

  logic Clk;
  logic Reset_n;
  logic Run;
  logic ClearA_LoadB;
  logic M;
  logic Clear_AX;
  logic Ld_B;
  logic Ld_A;
  logic Shift_En;
  logic Fn;
  logic Busy;
  logic Done;

  exp_item_t exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;
  bit summary_done = 0;

  multiplier_control #(.WIDTH(W)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Run         (Run),
    .ClearA_LoadB(ClearA_LoadB),
    .M           (M),
    .Clear_AX    (Clear_AX),
    .Ld_B        (Ld_B),
    .Ld_A        (Ld_A),
    .Shift_En    (Shift_En),
    .Fn          (Fn),
    .Busy        (Busy),
    .Done        (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Expected control word k cycles after Run was sampled in IDLE (k=0 is that IDLE cycle).
  function automatic outs_t expOp(input int k, input logic mv);
    outs_t e = NONE;
    if (k >= 1 && k <= 2*W + 1) e.busy = 1'b1;
    if (k == 1) begin
      e.clear_ax = 1'b1;
    end else if (k >= 2 && k <= 2*W && (k % 2) == 0) begin
      e.ld_a = mv;
      e.fn   = (k == 2*W);
    end else if (k >= 3 && k <= 2*W + 1) begin
      e.shift_en = 1'b1;
    end else if (k >= 2*W + 2) begin
      e.done = 1'b1;
    end
    return e;
  endfunction

  function automatic logic mBit(input int mode, input int k);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      default: return ((k % 3) == 0);
    endcase
  endfunction

  task automatic applyStimulus(input logic r, input logic c, input logic mv, input logic rn,
                               input outs_t e, input string name, input int k);
    exp_item_t it;
    Run          = r;
    ClearA_LoadB = c;
    M            = mv;
    Reset_n      = rn;
    it.e    = e;
    it.name = name;
    it.k    = k;
    exp_q.push_back(it);
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input exp_item_t it);
    outs_t got;
    got = {Clear_AX, Ld_B, Ld_A, Shift_En, Fn, Busy, Done};
    tests_run++;
    if (got !== it.e) begin
      tests_failed++;
      $display("[TB] FAIL %s cycle %0d: got {clr,ldb,lda,sh,fn,busy,done}=%b, expected %b",
               it.name, it.k, got, it.e);
    end
  endtask

  // One complete operation; Run stays high for run_len cycles, ClearA_LoadB pulses in [clr_from,clr_to].
  task automatic runOperation(input string name, input int run_len, input int m_mode,
                              input int clr_from, input int clr_to);
    logic r, c, mv;
    for (int k = 0; k < 400; k++) begin
      r  = (k < run_len);
      c  = (k >= clr_from && k <= clr_to);
      mv = mBit(m_mode, k);
      applyStimulus(r, c, mv, 1'b1, expOp(k, mv), name, k);
      if (k >= 2*W + 2 && !r) break;
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, NONE, {name, "_idle"}, -1);
  endtask

  task automatic printSummary();
    if (!summary_done) begin
      summary_done = 1;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    end
  endtask

  always @(negedge Clk) begin
    if (exp_q.size() != 0) checkOutput(exp_q.pop_front());
  end

  initial begin
    Reset_n      = 1'b0;
    Run          = 1'b1;
    ClearA_LoadB = 1'b1;
    M            = 1'b1;
    @(posedge Clk);
    #1;

    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, NONE, "in_reset", 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, NONE, "in_reset", 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, NONE, "post_reset_idle", 0);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, CLR_LD, "clear_load", 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, NONE, "clear_stays_idle", 1);

    runOperation("all_ones", 2*W + 3, 1, NO_CLR, -1);
    runOperation("zeros_pulse", 1, 0, 5, 6);
    runOperation("run_held", 40, 2, NO_CLR, -1);
    runOperation("second_press", 1, 1, NO_CLR, -1);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, CLR_LD, "run_and_clear", 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, NONE, "no_start", 1);
    runOperation("run_alone", 1, 0, NO_CLR, -1);

    for (int k = 0; k < 10; k++)
      applyStimulus(k == 0, 1'b0, 1'b1, 1'b1, expOp(k, 1'b1), "pre_reset", k);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, NONE, "reset_in_add", 10);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, NONE, "reset_held", 11);
    for (int k = 0; k < 4; k++)
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, NONE, "idle_after_reset", k);
    runOperation("restart", 1, 1, NO_CLR, -1);

    @(negedge Clk);
    #1;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL drain: %0d expected entries left, 0 required", exp_q.size());
    end
    printSummary();
    $finish;
  end

  initial begin
    #200000;
    tests_failed++;
    $display("[TB] FAIL watchdog: time limit reached, sequence still running");
    printSummary();
    $finish;
  end

endmodule
